// File: rtl/cpu_pkg.sv
// Shared definitions for the boot-time program loader: FSM encoding and word geometry.
package cpu_pkg;

  localparam int BYTES_PER_WORD = 4;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_WRITE = 3'd2,
    S_CHECK = 3'd3,
    S_RUN   = 3'd4,
    S_ERR   = 3'd5
  } state_t;

endpackage

// File: rtl/prog_loader.sv
// Byte-stream program loader: count byte, 4*N little-endian data bytes, XOR checksum,
// written into instruction RAM; releases the core only after a verified load.
module prog_loader
  import cpu_pkg::*;
#(
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic                  rx_ready,
  input  logic                  restart,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]           imem_data,
  output logic                  imem_we,
  output logic                  core_run,
  output logic                  err
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [1:0] LAST_BYTE = 2'(BYTES_PER_WORD - 1);
  localparam logic [ADDR_WIDTH:0] ONE_W = (ADDR_WIDTH+1)'(1);

  state_t                state, state_nxt;
  logic [ADDR_WIDTH:0]   n_words;
  logic [ADDR_WIDTH-1:0] widx;
  logic [1:0]            bcnt;
  logic [7:0]            csum;
  logic [31:0]           word;
  logic                  n_ok, last_word, take;

  assign n_ok      = (rx_data != 8'd0) && ({24'd0, rx_data} <= 32'(DEPTH));
  // Compare in ADDR_WIDTH+1 bits so a full-depth load terminates although widx wraps.
  assign last_word = ({1'b0, widx} + ONE_W) == n_words;
  assign take      = rx_valid && rx_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    rx_ready  = 1'b0;
    imem_we   = 1'b0;
    core_run  = 1'b0;
    err       = 1'b0;
    unique case (state)
      S_IDLE: begin
        rx_ready = 1'b1;
        if (rx_valid) state_nxt = n_ok ? S_LOAD : S_ERR;
      end
      S_LOAD: begin
        rx_ready = 1'b1;
        if (rx_valid && bcnt == LAST_BYTE) state_nxt = S_WRITE;
      end
      S_WRITE: begin
        imem_we   = 1'b1;
        state_nxt = last_word ? S_CHECK : S_LOAD;
      end
      S_CHECK: begin
        rx_ready = 1'b1;
        if (rx_valid) state_nxt = (rx_data == csum) ? S_RUN : S_ERR;
      end
      S_RUN: begin
        core_run = 1'b1;
        if (restart) state_nxt = S_IDLE;
      end
      S_ERR: begin
        err = 1'b1;
        if (restart) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Write address/data are registered on the 4th byte so they are stable in WRITE
  // and keep their value afterwards.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      n_words   <= '0;
      widx      <= '0;
      bcnt      <= '0;
      csum      <= '0;
      word      <= '0;
      imem_addr <= '0;
      imem_data <= '0;
    end else begin
      unique case (state)
        S_IDLE: if (take) begin
          n_words <= (ADDR_WIDTH+1)'(rx_data);
          widx    <= '0;
          bcnt    <= '0;
          csum    <= '0;
        end
        S_LOAD: if (take) begin
          csum <= csum ^ rx_data;
          bcnt <= bcnt + 2'd1;
          word[{bcnt, 3'b000} +: 8] <= rx_data;
          if (bcnt == LAST_BYTE) begin
            imem_addr <= widx;
            imem_data <= {rx_data, word[23:0]};
          end
        end
        S_WRITE: widx <= widx + ADDR_WIDTH'(1);
        S_RUN, S_ERR: if (restart) begin
          widx <= '0;
          bcnt <= '0;
          csum <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Randomized bench for prog_loader against a stream-level model of the load protocol.
module tb_prog_loader;

  localparam int AW    = 4;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [7:0]    rx_data = '0;
  logic          rx_valid = 1'b0;
  logic          rx_ready;
  logic          restart = 1'b0;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_data;
  logic          imem_we;
  logic          core_run;
  logic          err;

  always #5 clk = ~clk;

  prog_loader #(.ADDR_WIDTH(AW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .restart  (restart),
    .imem_addr(imem_addr),
    .imem_data(imem_data),
    .imem_we  (imem_we),
    .core_run (core_run),
    .err      (err)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int stalls  = 0;
  logic [AW+31:0] wr_q[$];
  logic [31:0]    words[DEPTH];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Observed write port traffic and cycles where an offered byte was refused.
  always @(negedge clk) if (imem_we) wr_q.push_back({imem_addr, imem_data});
  always @(posedge clk) if (rx_valid && !rx_ready) stalls++;

  // Called at a negedge; returns at the negedge after the byte is accepted.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int w = 0;
    rx_data  = b;
    rx_valid = 1'b1;
    while (!rx_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (w >= 50) begin
      check("rx_ready_wait", 64'(rx_ready), 64'd1);
      rx_valid = 1'b0;
      return;
    end
    @(negedge clk);
    if (gap > 0) begin
      rx_valid = 1'b0;
      repeat (gap) @(negedge clk);
    end
  endtask

  function automatic logic [7:0] xor_of(input int n);
    logic [7:0] x = 8'h00;
    for (int i = 0; i < n; i++)
      x ^= words[i][7:0] ^ words[i][15:8] ^ words[i][23:16] ^ words[i][31:24];
    return x;
  endfunction

  task automatic run_load(input logic [7:0] nb, input logic [7:0] cs, input int gap, input string tag);
    bit ok_n, exp_run;
    int n_exp;
    ok_n  = (nb >= 1) && (nb <= DEPTH);
    n_exp = ok_n ? int'(nb) : 0;
    wr_q.delete();
    stalls = 0;
    send_byte(nb, gap);
    if (ok_n) begin
      for (int w = 0; w < n_exp; w++)
        for (int b = 0; b < 4; b++)
          send_byte(words[w][8*b +: 8], gap);
      send_byte(cs, gap);
    end
    rx_valid = 1'b0;
    repeat (2) @(negedge clk);
    exp_run = ok_n && (cs == xor_of(n_exp));
    check({tag, ":nwr"}, 64'(wr_q.size()), 64'(n_exp));
    for (int i = 0; i < wr_q.size() && i < n_exp; i++) begin
      check({tag, ":addr"}, 64'(wr_q[i][AW+31:32]), 64'(i));
      check({tag, ":data"}, 64'(wr_q[i][31:0]), 64'(words[i]));
    end
    if (gap == 0) check({tag, ":stalls"}, 64'(stalls), 64'(n_exp));
    check({tag, ":run"}, 64'(core_run), 64'(exp_run));
    check({tag, ":err"}, 64'(err), 64'(!exp_run));
    check({tag, ":rdy"}, 64'(rx_ready), 64'd0);
  endtask

  task automatic do_restart(input string tag);
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    check({tag, ":rst_rdy"}, 64'(rx_ready), 64'd1);
    check({tag, ":rst_run"}, 64'(core_run), 64'd0);
    check({tag, ":rst_err"}, 64'(err), 64'd0);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, ":we"},   64'(imem_we), 64'd0);
    check({tag, ":addr"}, 64'(imem_addr), 64'd0);
    check({tag, ":data"}, 64'(imem_data), 64'd0);
    check({tag, ":run"},  64'(core_run), 64'd0);
    check({tag, ":err"},  64'(err), 64'd0);
    check({tag, ":rdy"},  64'(rx_ready), 64'd1);
  endtask

  initial begin
    logic [7:0] nb, cs;
    repeat (2) @(negedge clk);
    check_reset_state("por");
    rst_n = 1'b1;
    @(negedge clk);

    words[0] = 32'h12345678;
    run_load(8'd1, 8'h08, 0, "one_word");
    do_restart("one_word");

    words[0] = 32'h1; words[1] = 32'h2;
    run_load(8'd2, 8'h03, 1, "gapped");
    do_restart("gapped");

    words[0] = 32'h1;
    run_load(8'd1, 8'hFF, 0, "bad_cs");
    do_restart("bad_cs");

    run_load(8'd0, 8'h00, 0, "n0");
    do_restart("n0");
    run_load(8'd17, 8'h00, 0, "n17");
    do_restart("n17");

    for (int i = 0; i < DEPTH; i++) words[i] = $urandom;
    run_load(8'(DEPTH), xor_of(DEPTH), 0, "full");
    do_restart("full");

    // Reset partway through word 0, then a fresh load must still succeed.
    words[0] = 32'hA5A5_0F0F;
    send_byte(8'd1, 0);
    send_byte(8'h0F, 0);
    send_byte(8'h0F, 0);
    rx_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    check_reset_state("midrst");
    rst_n = 1'b1;
    @(negedge clk);
    run_load(8'd1, xor_of(1), 0, "after_rst");
    do_restart("after_rst");

    for (int it = 0; it < 20; it++) begin
      if ($urandom_range(0, 3) == 0)
        nb = ($urandom_range(0, 1) == 0) ? 8'd0 : 8'($urandom_range(DEPTH + 1, 255));
      else
        nb = 8'($urandom_range(1, DEPTH));
      for (int i = 0; i < DEPTH; i++) words[i] = $urandom;
      cs = (nb >= 1 && nb <= DEPTH) ? xor_of(int'(nb)) : 8'h00;
      if ($urandom_range(0, 2) == 0) cs ^= 8'($urandom_range(1, 255));
      run_load(nb, cs, int'($urandom_range(0, 2)), "rand");
      do_restart("rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 4, giving the instruction memory word-address width (depth = 2^ADDR_WIDTH words).
REQ-002 SHALL have port clk, input, 1, the single clock; all logic on the rising edge.
REQ-003 SHALL have port rst_n, input, 1; reset is synchronous and active-low.
REQ-004 SHALL have port rx_data, input, 8, the incoming byte.
REQ-005 SHALL have port rx_valid, input, 1; rx_data is valid this cycle.
REQ-006 SHALL have port rx_ready, output, 1; the loader can accept a byte this cycle.
REQ-007 SHALL have port restart, input, 1; a single-cycle pulse that requests a new load.
REQ-008 SHALL have port imem_addr, output, ADDR_WIDTH, the instruction memory write address.
REQ-009 SHALL have port imem_data, output, 32, the instruction memory write data.
REQ-010 SHALL have port imem_we, output, 1, the instruction memory write strobe.
REQ-011 SHALL have port core_run, output, 1; the core is released from hold when 1.
REQ-012 SHALL have port err, output, 1; the load failed.

Function
REQ-013 SHALL accept a byte only in a cycle where rx_valid and rx_ready are both 1.
REQ-014 SHALL implement states IDLE, LOAD, WRITE, CHECK, RUN, ERR.
REQ-015 SHALL hold rx_ready=1 in IDLE, LOAD and CHECK, and rx_ready=0 in WRITE, RUN and ERR.
REQ-016 SHALL, in IDLE, take the accepted byte as word count N; if 1 <= N <= 2^ADDR_WIDTH it SHALL go to LOAD with word index 0, otherwise it SHALL go to ERR.
REQ-017 SHALL, in LOAD, assemble 4 bytes per word, little-endian: first byte to [7:0], last byte to [31:24].
REQ-018 SHALL enter WRITE on the cycle after the 4th byte of a word is accepted.
REQ-019 SHALL, in WRITE, hold imem_we=1 for exactly one cycle, with imem_addr = word index and imem_data = the assembled word.
REQ-020 SHALL increment the word index after each WRITE; the next state SHALL be LOAD if the index < N, else CHECK.
REQ-021 SHALL keep a running XOR checksum, 8 bits, of all 4*N data bytes; the count byte SHALL be excluded.
REQ-022 SHALL, in CHECK, go to RUN if the accepted byte equals the checksum, else go to ERR.
REQ-023 SHALL hold core_run=1 only in RUN, and err=1 only in ERR.
REQ-024 SHALL hold imem_we=0 in every state other than WRITE; imem_addr and imem_data SHALL hold their last values outside WRITE.
REQ-025 SHALL, on restart=1 in RUN or ERR, go to IDLE on the next cycle, clearing core_run, err, the word index and the checksum.
REQ-026 SHALL ignore restart in IDLE, LOAD, WRITE and CHECK.
REQ-027 SHALL use modulo-2^ADDR_WIDTH word-index arithmetic; the index SHALL never exceed N-1 at any write.
REQ-028 SHALL ignore rx_valid in WRITE, RUN and ERR; no byte is consumed in those states.

Reset
REQ-029 SHALL, on clk edge with rst_n=0, enter IDLE with imem_we=0, core_run=0, err=0, imem_addr=0, imem_data=0, word index=0, byte count=0 and checksum=0.
REQ-030 SHALL, on reset mid-load, abandon the load; words already written stay in memory, but core_run SHALL stay 0 until a complete, valid load is done.
REQ-031 SHALL give rst_n priority over restart and over rx handshakes.

Structure
REQ-032 SHALL place the state encoding and the constant BYTES_PER_WORD=4 in a shared package, cpu_pkg.
REQ-033 SHALL be a single module with no sub-modules.
REQ-034 SHALL drive a dual-port instruction RAM write port, so that cpu_top can drive core reset from !core_run.

Verification
REQ-035 SHALL cover this case: N=1, bytes 78 56 34 12, checksum 0x08 -> one imem_we pulse, addr 0, data 0x12345678; then RUN, core_run=1.
REQ-036 SHALL cover this case: N=2, words 0x00000001 and 0x00000002, checksum 0x03, with rx_valid gapped by 1 idle cycle per byte -> writes to addr 0 then addr 1, then RUN.
REQ-037 SHALL cover this case: N=1, bytes 01 00 00 00, checksum 0xFF -> err=1, core_run=0; then restart -> IDLE with rx_ready=1.
REQ-038 SHALL cover count bytes N=0 and N=17 (ADDR_WIDTH=4) -> ERR, with no imem_we.
REQ-039 SHALL cover this case: N=16, full depth, correct checksum -> 16 writes to addr 0..15, then RUN; with rx_valid held 1 throughout, rx_ready=0 for exactly 1 cycle after every 4th byte.
REQ-040 SHALL cover this case: rst_n=0 asserted after 2 bytes of word 0 -> IDLE next cycle, all outputs at reset values; a fresh valid load then reaches RUN.
